// File: rtl/serial_switch_scanner_pkg.sv
// Shared types and helpers for the serial switch/button scanner.
package serial_in_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        UPDATE = 2'd3
    } state_e;

    // Reverse bit order inside each whole byte of the low 'width' bits;
    // bits above the last whole byte pass through unchanged.
    function automatic logic [63:0] rev_in_byte(input int width, input logic [63:0] vec);
        logic [63:0] r;
        logic [5:0]  d;
        r = vec;
        for (int i = 0; i < 64; i++) begin
            d = 6'(i);
            if (i < (width / 8) * 8) r[d] = vec[{d[5:3], ~d[2:0]}];
        end
        return r;
    endfunction

endpackage

// File: rtl/sin_debounce_bit.sv
// One debounced bit: accepts a new raw value only after DEBOUNCE_SCANS
// consecutive scans that disagree with the current debounced value.
module sin_debounce_bit
    import serial_in_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_upd,
    input  logic i_raw,
    output logic o_deb,
    output logic o_chg
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [CW-1:0] cnt;

    // This update flips the debounced value (only meaningful with i_upd).
    assign o_chg = (i_raw != o_deb) && (cnt == CW'(DEBOUNCE_SCANS - 1));

    // Agreement clears the run; a disagreement run of full length commits the new value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt   <= '0;
            o_deb <= 1'b0;
        end else if (i_upd) begin
            if (i_raw == o_deb) begin
                cnt <= '0;
            end else if (o_chg) begin
                o_deb <= i_raw;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_switch_scanner.sv
// Scans a parallel-load shift-register chain, deserialises one frame per scan,
// debounces every bit across scans and publishes switch/button fields.
module serial_switch_scanner
    import serial_in_pkg::*;
#(
    parameter int N_BITS         = 21,
    parameter int SW_BITS        = 16,
    parameter int DIV            = 4,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REV_IN_BYTE    = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_ser_data,
    output logic                      o_ser_load,
    output logic                      o_ser_clk,
    output logic [SW_BITS-1:0]        o_sw,
    output logic [N_BITS-SW_BITS-1:0] o_btn,
    output logic [N_BITS-SW_BITS-1:0] o_btn_press,
    output logic                      o_changed,
    output logic                      o_scan_valid
);

    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int KW = (N_BITS > 2) ? $clog2(N_BITS) : 1;

    state_e            state, state_nxt;
    logic [DW-1:0]     div;
    logic [KW-1:0]     bit_k;
    logic [N_BITS-1:0] raw, deb, chg;
    logic              div_last, bit_last, sample, upd;

    assign div_last = (div == DW'(DIV - 1));
    assign bit_last = (bit_k == KW'(N_BITS - 1));
    assign sample   = (div == DW'(DIV / 2 - 1));
    assign upd      = (state == UPDATE);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: one load period, N_BITS bit periods, one update cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_en) state_nxt = LOAD;
            LOAD:    if (div_last) state_nxt = SHIFT;
            SHIFT:   if (div_last && bit_last) state_nxt = UPDATE;
            UPDATE:  state_nxt = i_en ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Chain controls: load low during LOAD, shift clock high in second half of each bit period
    always_comb begin
        o_ser_load = 1'b1;
        o_ser_clk  = 1'b0;
        case (state)
            LOAD:    o_ser_load = 1'b0;
            SHIFT:   o_ser_clk  = (div >= DW'(DIV / 2));
            default: ;
        endcase
    end

    // Bit-period divider and bit index, parked at zero outside LOAD/SHIFT
    always_ff @(posedge i_clk) begin
        if (i_rst || !(state == LOAD || state == SHIFT)) begin
            div   <= '0;
            bit_k <= '0;
        end else begin
            div <= div_last ? '0 : div + 1'b1;
            if (state == SHIFT && div_last) bit_k <= bit_last ? '0 : bit_k + 1'b1;
        end
    end

    // Raw frame shift register; first bit received ends up in raw[0]
    always_ff @(posedge i_clk) begin
        if (i_rst)                   raw <= '0;
        else if (state == SHIFT && sample) raw <= {i_ser_data, raw[N_BITS-1:1]};
    end

    for (genvar g = 0; g < N_BITS; g++) begin : g_deb
        sin_debounce_bit #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_upd (upd),
            .i_raw (raw[g]),
            .o_deb (deb[g]),
            .o_chg (chg[g])
        );
    end

    // Per-scan strobes line up with the debounced values they describe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_scan_valid <= 1'b0;
            o_changed    <= 1'b0;
            o_btn_press  <= '0;
        end else begin
            o_scan_valid <= upd;
            o_changed    <= upd && (|chg);
            o_btn_press  <= upd ? (chg[N_BITS-1:SW_BITS] & raw[N_BITS-1:SW_BITS]) : '0;
        end
    end

    assign o_btn = deb[N_BITS-1:SW_BITS];

    if (REV_IN_BYTE != 0) begin : g_rev
        assign o_sw = SW_BITS'(rev_in_byte(SW_BITS, 64'(deb[SW_BITS-1:0])));
    end else begin : g_norev
        assign o_sw = deb[SW_BITS-1:0];
    end

endmodule
